hyperram_target: RTL and testbench
==================================

# hyperram_target

Synthesizable HyperBus target (device-side responder) that answers the controller's word-level bus: it decodes the 48-bit command/address, applies initial latency, and serves register and memory reads and writes from an internal word array. It sits opposite the HyperRAM controller on the same single-clock, one-16-bit-word-per-cycle bus abstraction. It is used for on-chip loopback, FPGA bring-up without a physical device, and as a DUT-side model in controller benches.

## Interface
- `DEPTH`, 4096: memory words; power of two.
- `AW`, 12: log2(`DEPTH`).
- `LATENCY`, 6: initial latency L in ck_en-qualified cycles.
- `ID0_VAL`, 16'h0C81: ID0 contents.
- `ID1_VAL`, 16'h0001: ID1 contents.
- `clk` in 1: bus clock.
- `rst` in 1: reset, asynchronous, active-high.
- `csn` in 1: chip select, active low, from controller `csn`.
- `ck_en` in 1: bus clock enable, from controller `oe_clk`. Only edges with `csn`=0 and `ck_en`=1 advance the target ("active edges").
- `bus_in` in 16: word from controller `datain`.
- `rwds_in` in 1: write mask from controller `rwds_out`; 1 = word masked.
- `rwds_oe_in` in 1: controller `rwds_oe`; informational only.
- `bus_out` out 16: read word, to controller `dataout`.
- `bus_oe` out 1: `bus_out` drive enable.
- `rwds_out` out 1: to controller `rwds_in`.
- `rwds_oe` out 1: `rwds_out` drive enable.

## Operation
- CA is 3 words, MSW first: CA[47:32], CA[31:16], CA[15:0].
- CA[47]=1 means read.
- CA[46]=1 selects register space.
- CA[45]=1 selects a linear burst; 0 selects a wrapped burst.
- Word address = {CA[44:16], CA[2:0]} truncated to `AW` bits.
- Register select = {CA[24], CA[0]}: 00 ID0, 01 ID1, 10 CR0, 11 CR1.
- CR0 resets to 16'h8F1F; CR1 resets to 16'hFFC1. Both are writable.
- ID0/ID1 are read-only; writes to them are ignored.
- CR0[3]=1 selects fixed 2× latency. CR0[1:0] sets wrap length in words: 00→64, 01→32, 10→8, 11→16.
- States:
  - IDLE → CA on the first active edge; CA word 0 is captured on that edge.
  - CA → LAT when the third CA word is captured. Exception: register write goes to REGWR.
  - LAT → RDATA or WDATA after the latency count.
  - REGWR → DONE.
  - RDATA and WDATA loop until `csn` rises.
  - DONE: all inputs ignored.
- `csn`=1 sampled on any edge → IDLE on that edge from any state; `bus_oe`=0 and `rwds_oe`=0 on that same edge.
- Latency count Lc = 2L if CR0[3]=1, else L. It is loaded on the CA2 capture edge and decremented per active edge.
- Register reads also use Lc.
- Burst address increments by 1 per data word.
  - Linear bursts wrap at `DEPTH`−1→0.
  - Wrapped bursts wrap within the aligned group of the CR0-selected length.
- Register reads return the same register on every data word.
- Write data: a word is stored only if `rwds_in`=0 on its active edge.
- REGWR stores `bus_in` into CR0/CR1 on the first active edge after CA2 (zero latency). Further words are ignored.
- A CR0 write takes effect from the next transaction.
- Memory writes past the last word of the burst are prevented only by `csn`; the target never stops a burst.

## Timing
- Reset values: `bus_out`=0, `bus_oe`=0, `rwds_out`=0, `rwds_oe`=0, state IDLE, CR0/CR1 at their reset values. The memory array is not reset.
- CA phase:
  - `rwds_oe`=1 from the CA0 edge through the LAT state.
  - `rwds_out`=CR0[3] during that interval, signalling 2× latency.
- Read:
  - Word 0 is registered onto `bus_out` on the Lc-th active edge after the CA2 edge.
  - Word n appears on the (Lc+n)-th active edge after CA2.
  - `bus_oe`=1 and `rwds_oe`=1 from word 0 onward.
  - `rwds_out`=1 for exactly the cycles following edges that presented a new word; otherwise 0.
  - With `ck_en`=0, `bus_out` holds and `rwds_out`=0.
- Write: word 0 is sampled on the Lc-th active edge after CA2; word n on the (Lc+n)-th.
- Simultaneous events:
  - `csn` rise wins over any data or CA edge; a word on that edge is not written.
  - Async `rst` mid-burst returns to reset values immediately, and the next access sees CR0/CR1 at their reset values.
- Partial CA (fewer than 3 words, then `csn`=1) → IDLE, no side effects.

## Structure
- Shared package `hyperbus_pkg` holds:
  - CA bit-position constants.
  - Register-select encodings.
  - CR0/CR1 reset constants.
  - Wrap-length decode function.
  - The target state enum typedef.
- Submodule `hyperram_target_mem`: single-port `DEPTH`×16 synchronous RAM with word write enable and registered read. The FSM issues the read address one active edge ahead to absorb RAM latency.

## Test plan
- Reset, then read ID0 (CA 48'hC000_0000_0000) → word 0 = 16'h0C81 with `rwds_out`=1 on the 12th active edge after CA2, since CR0[3]=1 by default.
- Write CR0=16'h8F17 (CA 48'h6000_0100_0000, data next edge) → read CR0 returns 16'h8F17. A subsequent read shows `rwds_out`=0 during CA and word 0 on the 6th active edge.
- Linear write of 4 words 16'h1111..16'h4444 at address `DEPTH`−2 with `rwds_in`=1 on the second word → read back 16'h1111, old value, 16'h3333, 16'h4444 at addresses `DEPTH`−2, `DEPTH`−1, 0, 1.
- Wrapped read, CR0[1:0]=10, start address 6 → word order 6,7,0,1,2,…
- `csn` raised after the second CA word, then a new read → correct data, no stray write. Assert `rst` mid-read → all outputs 0 immediately and CR0 back to 16'h8F1F.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: CA field positions, register selects, CR reset values,
// wrap-length decode and the target state encoding.
package hyperbus_pkg;

    localparam int CA_RW_BIT     = 47;
    localparam int CA_AS_BIT     = 46;
    localparam int CA_BURST_BIT  = 45;
    localparam int CA_SEL_HI_BIT = 24;
    localparam int CA_SEL_LO_BIT = 0;

    localparam logic [1:0] REG_ID0 = 2'b00;
    localparam logic [1:0] REG_ID1 = 2'b01;
    localparam logic [1:0] REG_CR0 = 2'b10;
    localparam logic [1:0] REG_CR1 = 2'b11;

    localparam logic [15:0] CR0_RST = 16'h8F1F;
    localparam logic [15:0] CR1_RST = 16'hFFC1;

    // CR0[1:0] wrapped-burst length in words
    function automatic logic [6:0] wrap_len(input logic [1:0] code);
        case (code)
            2'b00:   wrap_len = 7'd64;
            2'b01:   wrap_len = 7'd32;
            2'b10:   wrap_len = 7'd8;
            default: wrap_len = 7'd16;
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_REGWR,
        ST_RDATA,
        ST_WDATA,
        ST_DONE
    } tgt_state_e;

endpackage

// File: rtl/hyperram_target_mem.sv
// DEPTH x 16 single-port RAM, write-enable per word, registered read (1 enabled edge).
// No backpressure: a read holds its output until the next enabled read.
module hyperram_target_mem #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wr_dat,
    output logic [15:0]   rd_dat
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_dat;
        end
        if (re) begin
            rd_dat_q <= mem_q[addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/hyperram_target.sv
// HyperBus target: decodes 3-word CA, waits Lc active edges, then streams reads/writes.
// Only csn=0 & ck_en=1 edges advance; csn=1 aborts to IDLE; the target never stalls a burst.
module hyperram_target
    import hyperbus_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          AW      = 12,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0_VAL = 16'h0C81,
    parameter logic [15:0] ID1_VAL = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csn,
    input  logic        ck_en,
    input  logic [15:0] bus_in,
    input  logic        rwds_in,
    input  logic        rwds_oe_in,
    output logic [15:0] bus_out,
    output logic        bus_oe,
    output logic        rwds_out,
    output logic        rwds_oe
);

    localparam int LW = $clog2(2 * LATENCY + 1);

    tgt_state_e    state_q, state_d;
    logic          ca_idx_q, ca_idx_d;
    logic [31:0]   ca_hi_q, ca_hi_d;      // CA[47:16]
    logic [LW-1:0] lat_q, lat_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          is_read_q, is_read_d;
    logic          is_reg_q, is_reg_d;
    logic          is_lin_q, is_lin_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   cr0_q, cr0_d;
    logic [15:0]   cr1_q, cr1_d;
    logic [15:0]   bus_out_q, bus_out_d;
    logic          bus_oe_q, bus_oe_d;
    logic          rwds_out_q, rwds_out_d;
    logic          rwds_oe_q, rwds_oe_d;

    logic          mem_we, mem_re, data_edge;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdat, reg_rd_dat;
    logic          unused_rwds_oe;

    assign unused_rwds_oe = rwds_oe_in;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic lin,
                                                input logic [1:0] wcode);
        logic [AW-1:0] m;
        m = AW'(wrap_len(wcode) - 7'd1);
        next_addr = lin ? a + AW'(1) : (a & ~m) | ((a + AW'(1)) & m);
    endfunction

    always_comb begin
        case (sel_q)
            REG_ID0: reg_rd_dat = ID0_VAL;
            REG_ID1: reg_rd_dat = ID1_VAL;
            REG_CR0: reg_rd_dat = cr0_q;
            default: reg_rd_dat = cr1_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ca_idx_d   = ca_idx_q;
        ca_hi_d    = ca_hi_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        is_reg_d   = is_reg_q;
        is_lin_d   = is_lin_q;
        sel_d      = sel_q;
        cr0_d      = cr0_q;
        cr1_d      = cr1_q;
        bus_out_d  = bus_out_q;
        bus_oe_d   = bus_oe_q;
        rwds_out_d = rwds_out_q;
        rwds_oe_d  = rwds_oe_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = addr_q;
        data_edge  = 1'b0;

        if (csn) begin
            state_d    = ST_IDLE;
            bus_oe_d   = 1'b0;
            rwds_oe_d  = 1'b0;
            rwds_out_d = 1'b0;
        end else begin
            // rwds strobes only on edges that present a new read word
            if (state_q == ST_RDATA) begin
                rwds_out_d = 1'b0;
            end
            if (ck_en) begin
                case (state_q)
                    ST_IDLE: begin
                        ca_hi_d[31:16] = bus_in;
                        ca_idx_d       = 1'b0;
                        state_d        = ST_CA;
                        rwds_oe_d      = 1'b1;
                        rwds_out_d     = cr0_q[3];
                    end
                    ST_CA: begin
                        if (!ca_idx_q) begin
                            ca_hi_d[15:0] = bus_in;
                            ca_idx_d      = 1'b1;
                        end else begin
                            is_read_d = ca_hi_q[CA_RW_BIT-16];
                            is_reg_d  = ca_hi_q[CA_AS_BIT-16];
                            is_lin_d  = ca_hi_q[CA_BURST_BIT-16];
                            addr_d    = AW'({ca_hi_q[CA_BURST_BIT-17:0], bus_in[2:0]});
                            sel_d     = {ca_hi_q[CA_SEL_HI_BIT-16], bus_in[CA_SEL_LO_BIT]};
                            lat_d     = cr0_q[3] ? LW'(2 * LATENCY) : LW'(LATENCY);
                            if (!ca_hi_q[CA_RW_BIT-16] && ca_hi_q[CA_AS_BIT-16]) begin
                                state_d    = ST_REGWR;
                                rwds_oe_d  = 1'b0;
                                rwds_out_d = 1'b0;
                            end else begin
                                state_d = ST_LAT;
                            end
                        end
                    end
                    ST_LAT: begin
                        lat_d  = lat_q - LW'(1);
                        mem_re = 1'b1;
                        if (lat_q == LW'(1)) begin
                            data_edge = 1'b1;
                            if (is_read_q) begin
                                state_d  = ST_RDATA;
                                bus_oe_d = 1'b1;
                            end else begin
                                state_d    = ST_WDATA;
                                rwds_oe_d  = 1'b0;
                                rwds_out_d = 1'b0;
                            end
                        end
                    end
                    ST_RDATA, ST_WDATA: data_edge = 1'b1;
                    ST_REGWR: begin
                        if (sel_q == REG_CR0) begin
                            cr0_d = bus_in;
                        end else if (sel_q == REG_CR1) begin
                            cr1_d = bus_in;
                        end
                        state_d = ST_DONE;
                    end
                    default: ;
                endcase

                // Reads prefetch the following address so the RAM output is ready next edge
                if (data_edge) begin
                    addr_d = next_addr(addr_q, is_lin_q, cr0_q[1:0]);
                    if (is_read_q) begin
                        bus_out_d  = is_reg_q ? reg_rd_dat : mem_rdat;
                        rwds_out_d = 1'b1;
                        mem_re     = 1'b1;
                        mem_addr   = addr_d;
                    end else begin
                        mem_we = !rwds_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ca_idx_q   <= 1'b0;
            ca_hi_q    <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            is_read_q  <= 1'b0;
            is_reg_q   <= 1'b0;
            is_lin_q   <= 1'b0;
            sel_q      <= REG_ID0;
            cr0_q      <= CR0_RST;
            cr1_q      <= CR1_RST;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            rwds_out_q <= 1'b0;
            rwds_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ca_idx_q   <= ca_idx_d;
            ca_hi_q    <= ca_hi_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            is_reg_q   <= is_reg_d;
            is_lin_q   <= is_lin_d;
            sel_q      <= sel_d;
            cr0_q      <= cr0_d;
            cr1_q      <= cr1_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            rwds_out_q <= rwds_out_d;
            rwds_oe_q  <= rwds_oe_d;
        end
    end

    hyperram_target_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .re     (mem_re),
        .addr   (mem_addr),
        .wr_dat (bus_in),
        .rd_dat (mem_rdat)
    );

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rwds_out = rwds_out_q;
    assign rwds_oe  = rwds_oe_q;

endmodule

// File: tb/tb_hyperram_target.sv
// Directed bench for hyperram_target: transaction-level reference model (word array + CRs)
// drives expectations; a negedge process compares outputs, plus literal spot checks.
module tb_hyperram_target;

    localparam int DEPTH = 4096;
    localparam int L     = 6;

    logic        clk = 1'b0;
    logic        rst, csn, ck_en, rwds_in, rwds_oe_in;
    logic [15:0] bus_in, bus_out;
    logic        bus_oe, rwds_out, rwds_oe;

    always #5 clk = ~clk;

    hyperram_target dut (
        .clk        (clk),
        .rst        (rst),
        .csn        (csn),
        .ck_en      (ck_en),
        .bus_in     (bus_in),
        .rwds_in    (rwds_in),
        .rwds_oe_in (rwds_oe_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .rwds_out   (rwds_out),
        .rwds_oe    (rwds_oe)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] m_cr0, m_cr1;

    logic        exp_vld = 1'b0;
    logic        e_boe, e_roe, chk_rwds, e_rw, chk_dat;
    logic [15:0] e_dat;

    logic [15:0] got [16];
    logic [15:0] wdat [16];
    logic        wmsk [16];
    int          act_cnt, oe_edge;
    logic        ca_rwds;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_vld && !rst) begin
            check("bus_oe", 16'(bus_oe), 16'(e_boe));
            check("rwds_oe", 16'(rwds_oe), 16'(e_roe));
            if (chk_rwds) check("rwds_out", 16'(rwds_out), 16'(e_rw));
            if (chk_dat) check("bus_out", bus_out, e_dat);
        end
    end

    task automatic set_exp(input logic boe, input logic roe, input logic crw, input logic rw,
                           input logic cd, input logic [15:0] dat);
        exp_vld = 1'b1; e_boe = boe; e_roe = roe; chk_rwds = crw; e_rw = rw;
        chk_dat = cd; e_dat = dat;
    endtask

    task automatic step(input logic c, input logic ce, input logic [15:0] d, input logic m);
        csn = c; ck_en = ce; bus_in = d; rwds_in = m;
        @(posedge clk);
        #1;
        if (!c && ce) act_cnt++;
        if (bus_oe && oe_edge == 0) oe_edge = act_cnt;
    endtask

    function automatic int wlen(input logic [15:0] cr0);
        case (cr0[1:0])
            2'b00:   return 64;
            2'b01:   return 32;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int model_addr(input logic [47:0] ca, input int n);
        logic [31:0] a32;
        int start, w;
        a32   = {ca[44:16], ca[2:0]};
        start = int'(a32 % 32'(DEPTH));
        if (ca[45]) return (start + n) % DEPTH;
        w = wlen(m_cr0);
        return start - (start % w) + ((start % w) + n) % w;
    endfunction

    function automatic logic [15:0] model_word(input logic [47:0] ca, input int n);
        if (ca[46]) begin
            case ({ca[24], ca[0]})
                2'b00:   return 16'h0C81;
                2'b01:   return 16'h0001;
                2'b10:   return m_cr0;
                default: return m_cr1;
            endcase
        end
        return ref_mem[model_addr(ca, n)];
    endfunction

    task automatic do_ca(input logic [47:0] ca, input logic regwr);
        step(0, 1, ca[47:32], 0);
        ca_rwds = rwds_out;
        set_exp(0, 1, 1, m_cr0[3], 0, 16'h0);
        step(0, 1, ca[31:16], 0);
        step(0, 1, ca[15:0], 0);
        if (regwr) exp_vld = 1'b0;
        act_cnt = 0;
        oe_edge = 0;
    endtask

    task automatic do_read(input logic [47:0] ca, input int n, input int stall_at, input bit fin);
        int lc;
        lc = m_cr0[3] ? 2 * L : L;
        do_ca(ca, 0);
        for (int k = 1; k < lc; k++) step(0, 1, 16'h0, 0);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                step(0, 0, 16'h0, 0);
                set_exp(1, 1, 1, 0, 1, model_word(ca, i - 1));
            end
            step(0, 1, 16'h0, 0);
            got[i] = bus_out;
            set_exp(1, 1, 1, 1, 1, model_word(ca, i));
        end
        if (fin) begin
            step(1, 1, 16'h0, 0);
            set_exp(0, 0, 0, 0, 0, 16'h0);
            step(1, 0, 16'h0, 0);
        end
    endtask

    task automatic do_write(input logic [47:0] ca, input int n);
        int lc;
        lc = m_cr0[3] ? 2 * L : L;
        do_ca(ca, 0);
        for (int k = 1; k < lc; k++) step(0, 1, 16'hBAD0, 0);
        for (int i = 0; i < n; i++) begin
            step(0, 1, wdat[i], wmsk[i]);
            set_exp(0, 0, 0, 0, 0, 16'h0);
            if (!wmsk[i]) ref_mem[model_addr(ca, i)] = wdat[i];
        end
        // a word on the csn-rise edge must not land in memory
        step(1, 1, 16'hDEAD, 0);
        step(1, 0, 16'h0, 0);
    endtask

    task automatic do_regwr(input logic [47:0] ca, input logic [15:0] val);
        do_ca(ca, 1);
        step(0, 1, val, 0);
        if ({ca[24], ca[0]} == 2'b10) m_cr0 = val;
        if ({ca[24], ca[0]} == 2'b11) m_cr1 = val;
        step(0, 1, 16'hDEAD, 0);
        step(1, 1, 16'hDEAD, 0);
        set_exp(0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 16'h0, 0);
    endtask

    initial begin
        rst = 1'b1; csn = 1'b1; ck_en = 1'b0; bus_in = 16'h0; rwds_in = 1'b0; rwds_oe_in = 1'b0;
        act_cnt = 0; oe_edge = 0; ca_rwds = 1'b0;
        m_cr0 = 16'h8F1F; m_cr1 = 16'hFFC1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_out", bus_out, 16'h0);
        check("rst_bus_oe", 16'(bus_oe), 16'h0);
        check("rst_rwds_out", 16'(rwds_out), 16'h0);
        check("rst_rwds_oe", 16'(rwds_oe), 16'h0);
        rst = 1'b0;
        step(1, 0, 16'h0, 0);
        set_exp(0, 0, 0, 0, 0, 16'h0);

        do_read(48'hC000_0000_0000, 2, -1, 1);
        check("id0_word0", got[0], 16'h0C81);
        check("id0_word1", got[1], 16'h0C81);
        check("id0_latency", 16'(oe_edge), 16'd12);
        check("id0_ca_rwds", 16'(ca_rwds), 16'h1);

        do_read(48'hE000_0100_0001, 1, -1, 1);
        check("cr1_reset", got[0], 16'hFFC1);

        do_regwr(48'h6000_0100_0000, 16'h8F17);
        do_regwr(48'h6000_0000_0001, 16'h1234);
        do_read(48'hE000_0100_0000, 1, -1, 1);
        check("cr0_written", got[0], 16'h8F17);
        check("cr0_ca_rwds", 16'(ca_rwds), 16'h0);
        check("cr0_latency", 16'(oe_edge), 16'd6);
        do_read(48'hC000_0000_0001, 1, -1, 1);
        check("id1_readonly", got[0], 16'h0001);

        wdat[0] = 16'hABCD; wmsk[0] = 1'b0;
        do_write(48'h2000_01FF_0007, 1);
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
        wmsk[0] = 1'b0; wmsk[1] = 1'b1; wmsk[2] = 1'b0; wmsk[3] = 1'b0;
        do_write(48'h2000_01FF_0006, 4);
        do_read(48'hA000_01FF_0006, 4, 2, 1);
        check("lin_w0", got[0], 16'h1111);
        check("lin_w1_masked", got[1], 16'hABCD);
        check("lin_w2_wrap0", got[2], 16'h3333);
        check("lin_w3", got[3], 16'h4444);

        do_regwr(48'h6000_0100_0000, 16'h8F16);
        for (int i = 0; i < 9; i++) begin
            wdat[i] = 16'h5000 + 16'(i);
            wmsk[i] = 1'b0;
        end
        do_write(48'h2000_0000_0000, 9);
        do_read(48'h8000_0000_0006, 6, -1, 1);
        check("wrap_w0", got[0], 16'h5006);
        check("wrap_w1", got[1], 16'h5007);
        check("wrap_w2", got[2], 16'h5000);
        check("wrap_w5", got[5], 16'h5003);

        step(0, 1, 16'h2000, 0);
        set_exp(0, 1, 1, 0, 0, 16'h0);
        step(0, 1, 16'h0000, 0);
        step(1, 1, 16'h0000, 0);
        set_exp(0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 16'hFFFF, 0);
        do_read(48'hA000_0000_0000, 2, -1, 1);
        check("partial_ca_w0", got[0], 16'h5000);
        check("partial_ca_w1", got[1], 16'h5001);

        do_read(48'hE000_0100_0000, 2, -1, 0);
        exp_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_bus_out", bus_out, 16'h0);
        check("midrst_bus_oe", 16'(bus_oe), 16'h0);
        check("midrst_rwds_out", 16'(rwds_out), 16'h0);
        check("midrst_rwds_oe", 16'(rwds_oe), 16'h0);
        m_cr0 = 16'h8F1F; m_cr1 = 16'hFFC1;
        step(1, 0, 16'h0, 0);
        rst = 1'b0;
        step(1, 0, 16'h0, 0);
        set_exp(0, 0, 0, 0, 0, 16'h0);
        do_read(48'hE000_0100_0000, 1, -1, 1);
        check("cr0_after_rst", got[0], 16'h8F1F);
        check("rst_latency", 16'(oe_edge), 16'd12);

        exp_vld = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
